// File: rtl/m_button_event_pkg.sv
// Shared button indices, direction codes and direction-FSM encoding for the
// button front end, the game FSM and the rotation-mode logic.
package m_button_event_pkg;

   localparam int BTN_RIGHT  = 0;
   localparam int BTN_LEFT   = 1;
   localparam int BTN_DOWN   = 2;
   localparam int BTN_UP     = 3;
   localparam int BTN_CENTER = 4;

   typedef enum logic [1:0] {
      DIR_RIGHT = 2'd0,
      DIR_LEFT  = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_UP    = 2'd3
   } dir_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HELD  = 2'd1,
      ST_MULTI = 2'd2
   } state_e;

   function automatic logic is_single(input logic [3:0] lvl);
      return (lvl != 4'd0) && ((lvl & (lvl - 4'd1)) == 4'd0);
   endfunction

   // Only meaningful when exactly one bit is set; the code equals the bit index.
   function automatic logic [1:0] dir_of(input logic [3:0] lvl);
      logic [1:0] v_dir;
      v_dir = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (lvl[i]) v_dir = 2'(i);
      end
      return v_dir;
   endfunction

endpackage

// File: rtl/m_debounce_bit.sv
// One button bit: 2-FF synchroniser followed by a stable-level debounce counter.
module m_debounce_bit #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_level
);

   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic [CNT_W-1:0] r_cnt;

   // The counter only advances while the synced level disagrees with the accepted one.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == LP_CNT_LAST) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_level = r_stable;

endmodule

// File: rtl/m_button_event.sv
// Debounced five-button front end: direction presses become handshaked answer
// events, the centre button becomes a one-cycle start pulse.
module m_button_event #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic       w_clk,
   input  logic       w_rst_n,
   input  logic [4:0] fivebuttons,
   output logic [4:0] btn_level,
   output logic       center_pulse,
   output logic       evt_valid,
   output logic [1:0] evt_dir,
   input  logic       evt_ack,
   output logic       evt_ovf,
   output logic       multi_err,
   output logic [1:0] o_dbg_state
);

   import m_button_event_pkg::*;

   logic [4:0] w_level;
   logic [3:0] w_dir_lvl;
   logic       w_single;
   logic       w_any;
   logic       w_create;
   logic       w_ack_ok;

   state_e     r_state;
   logic       r_evt_valid;
   logic [1:0] r_evt_dir;
   logic       r_evt_ovf;
   logic       r_multi_err;
   logic       r_center_q;
   logic       r_center_pulse;

   for (genvar gi = 0; gi < 5; gi++) begin : g_db
      m_debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_db (
         .i_clk  (w_clk),
         .i_rst_n(w_rst_n),
         .i_raw  (fivebuttons[gi]),
         .o_level(w_level[gi])
      );
   end

   assign w_dir_lvl = w_level[BTN_UP:BTN_RIGHT];
   assign w_single  = is_single(w_dir_lvl);
   assign w_any     = |w_dir_lvl;
   assign w_create  = (r_state == ST_IDLE) && w_single;
   assign w_ack_ok  = evt_ack && r_evt_valid;

   // valid/ready: the slot holds one event while evt_valid=1; evt_ack sampled
   // high with evt_valid=1 consumes it and the slot is free on the next cycle.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state        <= ST_IDLE;
         r_evt_valid    <= 1'b0;
         r_evt_dir      <= 2'd0;
         r_evt_ovf      <= 1'b0;
         r_multi_err    <= 1'b0;
         r_center_q     <= 1'b0;
         r_center_pulse <= 1'b0;
      end else begin
         r_evt_ovf      <= 1'b0;
         r_multi_err    <= 1'b0;
         r_center_q     <= w_level[BTN_CENTER];
         r_center_pulse <= w_level[BTN_CENTER] & ~r_center_q;

         case (r_state)
            ST_IDLE: begin
               if (w_single) begin
                  r_state <= ST_HELD;
               end else if (w_any) begin
                  r_state     <= ST_MULTI;
                  r_multi_err <= 1'b1;
               end
            end
            ST_HELD, ST_MULTI: begin
               if (!w_any) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase

         // A new event may reuse the slot in the very cycle its previous occupant is acked.
         if (w_create) begin
            if (!r_evt_valid || w_ack_ok) begin
               r_evt_valid <= 1'b1;
               r_evt_dir   <= dir_of(w_dir_lvl);
            end else begin
               r_evt_ovf <= 1'b1;
            end
         end else if (w_ack_ok) begin
            r_evt_valid <= 1'b0;
         end
      end
   end

   assign btn_level    = w_level;
   assign center_pulse = r_center_pulse;
   assign evt_valid    = r_evt_valid;
   assign evt_dir      = r_evt_dir;
   assign evt_ovf      = r_evt_ovf;
   assign multi_err    = r_multi_err;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_m_button_event.sv
// Directed bench for m_button_event with a short debounce window.
module tb_m_button_event;

   import m_button_event_pkg::*;

   localparam int D  = 4;
   localparam int CW = 3;

   logic       w_clk = 1'b0;
   logic       w_rst_n = 1'b0;
   logic [4:0] fivebuttons = 5'b0;
   logic       evt_ack = 1'b0;
   logic [4:0] btn_level;
   logic       center_pulse;
   logic       evt_valid;
   logic [1:0] evt_dir;
   logic       evt_ovf;
   logic       multi_err;
   logic [1:0] o_dbg_state;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int n_center = 0;
   int n_ovf = 0;
   int n_multi = 0;
   logic [1:0] exp_q[$];

   m_button_event #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W          (CW)
   ) dut (
      .w_clk       (w_clk),
      .w_rst_n     (w_rst_n),
      .fivebuttons (fivebuttons),
      .btn_level   (btn_level),
      .center_pulse(center_pulse),
      .evt_valid   (evt_valid),
      .evt_dir     (evt_dir),
      .evt_ack     (evt_ack),
      .evt_ovf     (evt_ovf),
      .multi_err   (multi_err),
      .o_dbg_state (o_dbg_state)
   );

   always #5 w_clk = ~w_clk;

   always @(negedge w_clk) begin
      if (w_rst_n) begin
         if (center_pulse) n_center++;
         if (evt_ovf) n_ovf++;
         if (multi_err) n_multi++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge w_clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) step();
   endtask

   task automatic settle();
      run_to(cyc + D + 4);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_event(input string tag);
      logic [1:0] v_exp;
      chk({tag, "_queued"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
         v_exp = exp_q.pop_front();
         chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
         chk({tag, "_dir"}, 32'(evt_dir), 32'(v_exp));
      end
   endtask

   task automatic ack_now(input string tag);
      evt_ack = 1'b1;
      step();
      chk({tag, "_acked"}, 32'(evt_valid), 32'd0);
      evt_ack = 1'b0;
   endtask

   task automatic press_and_take(input logic [4:0] btns, input logic [1:0] dir, input string tag);
      int t;
      t = cyc;
      fivebuttons = btns;
      exp_q.push_back(dir);
      run_to(t + D + 2);
      chk({tag, "_early"}, 32'(evt_valid), 32'd0);
      run_to(t + D + 3);
      check_event(tag);
   endtask

   initial begin
      int t;
      repeat (3) step();
      chk("rst_level", 32'(btn_level), 32'd0);
      chk("rst_valid", 32'(evt_valid), 32'd0);
      chk("rst_pulses", 32'({center_pulse, evt_ovf, multi_err}), 32'd0);
      chk("rst_state", 32'(o_dbg_state), 32'(ST_IDLE));
      w_rst_n = 1'b1;
      cyc = 0;

      // Clean up press at cycle 10, ack at 25.
      run_to(10);
      fivebuttons = 5'b01000;
      exp_q.push_back(2'd3);
      run_to(15);
      chk("t1_level_early", 32'(btn_level), 32'd0);
      run_to(16);
      chk("t1_level", 32'(btn_level), 32'b01000);
      chk("t1_valid_early", 32'(evt_valid), 32'd0);
      run_to(17);
      check_event("t1");
      run_to(25);
      chk("t1_hold_valid", 32'(evt_valid), 32'd1);
      chk("t1_hold_dir", 32'(evt_dir), 32'd3);
      evt_ack = 1'b1;
      step();
      chk("t1_ack_clear", 32'(evt_valid), 32'd0);
      evt_ack = 1'b0;
      fivebuttons = 5'b0;
      settle();
      chk("t1_release_level", 32'(btn_level), 32'd0);
      chk("t1_release_state", 32'(o_dbg_state), 32'(ST_IDLE));
      chk("t1_release_valid", 32'(evt_valid), 32'd0);

      // Bouncing up press, steady from relative cycle 20.
      t = cyc;
      run_to(t + 16); fivebuttons = 5'b01000;
      run_to(t + 18); fivebuttons = 5'b00000;
      run_to(t + 20); fivebuttons = 5'b01000;
      exp_q.push_back(2'd3);
      run_to(t + 25);
      chk("t2_level_early", 32'(btn_level), 32'd0);
      run_to(t + 26);
      chk("t2_valid_early", 32'(evt_valid), 32'd0);
      run_to(t + 27);
      check_event("t2");
      chk("t2_no_multi", 32'(n_multi), 32'd0);
      ack_now("t2");

      // Up still held; left added then released; a fresh left press follows.
      fivebuttons = 5'b01010;
      run_to(cyc + D + 5);
      chk("t3_no_event", 32'(evt_valid), 32'd0);
      chk("t3_no_multi", 32'(n_multi), 32'd0);
      chk("t3_state_held", 32'(o_dbg_state), 32'(ST_HELD));
      fivebuttons = 5'b0;
      settle();
      press_and_take(5'b00010, 2'd1, "t3_left");
      ack_now("t3_left");
      fivebuttons = 5'b0;
      settle();

      // Up and down together from idle.
      t = cyc;
      fivebuttons = 5'b01100;
      run_to(t + D + 2);
      chk("t4_multi_early", 32'(multi_err), 32'd0);
      run_to(t + D + 3);
      chk("t4_multi", 32'(multi_err), 32'd1);
      chk("t4_no_valid", 32'(evt_valid), 32'd0);
      run_to(t + D + 4);
      chk("t4_multi_one", 32'(multi_err), 32'd0);
      chk("t4_state", 32'(o_dbg_state), 32'(ST_MULTI));
      chk("t4_multi_count", 32'(n_multi), 32'd1);
      fivebuttons = 5'b0;
      settle();
      chk("t4_idle", 32'(o_dbg_state), 32'(ST_IDLE));
      press_and_take(5'b00001, 2'd0, "t4_right");
      ack_now("t4_right");
      fivebuttons = 5'b0;
      settle();

      // Overflow: up pending, up released, right pressed without ack.
      press_and_take(5'b01000, 2'd3, "t5_up");
      fivebuttons = 5'b0;
      settle();
      t = cyc;
      fivebuttons = 5'b00001;
      run_to(t + D + 2);
      chk("t5_ovf_early", 32'(evt_ovf), 32'd0);
      run_to(t + D + 3);
      chk("t5_ovf", 32'(evt_ovf), 32'd1);
      chk("t5_ovf_valid", 32'(evt_valid), 32'd1);
      chk("t5_ovf_dir", 32'(evt_dir), 32'd3);
      run_to(t + D + 4);
      chk("t5_ovf_one", 32'(evt_ovf), 32'd0);
      chk("t5_ovf_count", 32'(n_ovf), 32'd1);
      ack_now("t5_up");
      fivebuttons = 5'b0;
      settle();

      // Same again, but the ack coincides with the new event.
      press_and_take(5'b01000, 2'd3, "t5b_up");
      fivebuttons = 5'b0;
      settle();
      t = cyc;
      fivebuttons = 5'b00001;
      exp_q.push_back(2'd0);
      run_to(t + D + 2);
      evt_ack = 1'b1;
      step();
      evt_ack = 1'b0;
      check_event("t5b_swap");
      chk("t5b_no_ovf", 32'(evt_ovf), 32'd0);
      step();
      chk("t5b_still_valid", 32'(evt_valid), 32'd1);
      chk("t5b_ovf_count", 32'(n_ovf), 32'd1);
      ack_now("t5b_right");
      fivebuttons = 5'b0;
      settle();

      // Centre press, then reset in the middle of an up debounce.
      t = cyc;
      fivebuttons = 5'b10000;
      run_to(t + D + 3);
      chk("t6_center", 32'(center_pulse), 32'd1);
      chk("t6_center_no_evt", 32'(evt_valid), 32'd0);
      run_to(t + D + 4);
      chk("t6_center_one", 32'(center_pulse), 32'd0);
      chk("t6_center_count", 32'(n_center), 32'd1);
      chk("t6_center_level", 32'(btn_level), 32'b10000);
      t = cyc;
      fivebuttons = 5'b11000;
      run_to(t + 2);
      w_rst_n = 1'b0;
      #1;
      chk("t6_rst_level", 32'(btn_level), 32'd0);
      chk("t6_rst_outs", 32'({center_pulse, evt_valid, evt_dir, evt_ovf, multi_err}), 32'd0);
      step();
      step();
      w_rst_n = 1'b1;
      t = cyc;
      exp_q.push_back(2'd3);
      run_to(t + D + 2);
      chk("t6_post_early", 32'(evt_valid), 32'd0);
      run_to(t + D + 3);
      check_event("t6_post");
      chk("t6_post_center", 32'(center_pulse), 32'd1);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/m_button_event.md
# m_button_event

Input-conditioning stage directly upstream of the quiz/game state machine that drives the ST7789 frame writer. It synchronises and debounces the five raw push-buttons. It converts direction presses into single, handshaked answer events so the game FSM never samples raw bouncing levels. The centre button is reported as a one-cycle start pulse.

## Interface
- DEBOUNCE_CYCLES, 1_000_000 — consecutive stable cycles required to accept a level change (10 ms at 100 MHz); minimum 2.
- CNT_W, 20 — debounce counter width; must hold DEBOUNCE_CYCLES-1.
- w_clk  in  1  100 MHz system clock; one clock; all state on posedge.
- w_rst_n  in  1  asynchronous, active-low reset.
- fivebuttons  in  5  raw, asynchronous, active-high; [0]=right, [1]=left, [2]=down, [3]=up, [4]=center.
- btn_level  out  5  debounced levels, same bit order.
- center_pulse  out  1  one-cycle pulse on debounced center rising edge.
- evt_valid  out  1  answer event pending.
- evt_dir  out  2  direction of pending event: 0 right, 1 left, 2 down, 3 up (equals fivebuttons bit index).
- evt_ack  in  1  consumer accepts the pending event.
- evt_ovf  out  1  one-cycle pulse: a new event was dropped because one was pending.
- multi_err  out  1  one-cycle pulse: more than one direction became held from idle.

## Operation
- Per bit: 2-FF synchroniser, then debounce. The counter runs while the synced value differs from stable. It clears whenever they are equal. When it reaches DEBOUNCE_CYCLES-1, stable takes the synced value and the counter clears.
- Direction FSM, evaluated on debounced levels d[3:0]:
  - IDLE: all released. Exactly one set: create event with dir = its index, go to HELD. Two or more set in the same cycle: pulse multi_err, no event, go to MULTI.
  - HELD: additional presses are ignored (no event, no error). Go to IDLE only when d[3:0]==0.
  - MULTI: go to IDLE only when d[3:0]==0.
- Event slot behaviour:
  - Created event with slot empty: evt_valid=1, evt_dir set.
  - Slot cleared the cycle after evt_ack is sampled high with evt_valid=1.
  - evt_ack while evt_valid=0 is ignored.
  - Created event while slot full and no ack: event dropped, evt_ovf pulses, evt_dir unchanged.
  - Created event in the same cycle as an accepted ack: the new event is loaded, evt_valid stays 1, evt_dir updates, no evt_ovf.
- center_pulse is independent of the FSM and the event slot; it never sets evt_valid.

## Timing
- Reset (asynchronous, any time) immediately clears:
  - all outputs to 0;
  - synchronisers, stable levels, counters, FSM (IDLE) and event slot.
- A button held through reset release re-debounces from 0 and produces a normal event.
- Raw change at cycle t, held steady: btn_level changes at t+DEBOUNCE_CYCLES+2.
- evt_valid, center_pulse and multi_err assert at t+DEBOUNCE_CYCLES+3, driven from registers.
- A bounce shorter than DEBOUNCE_CYCLES restarts the count; latency is measured from the last edge.
- Release follows the same latency; releases produce no pulses.
- Handshake: ack sampled at cycle k with valid=1 gives evt_valid=0 at k+1, unless a new event is loaded at k.

## Structure
- Shared package/header holds:
  - button index constants (BTN_RIGHT=0, BTN_LEFT=1, BTN_DOWN=2, BTN_UP=3, BTN_CENTER=4);
  - 2-bit direction codes;
  - FSM state encoding IDLE/HELD/MULTI.
  The game FSM and the rotation-mode logic both use these.
- One sub-module, m_debounce_bit: synchroniser plus counter for one bit, parameterised by DEBOUNCE_CYCLES and CNT_W, instantiated five times. The FSM and event slot live in the top.

## Test plan
All runs use DEBOUNCE_CYCLES=4.
- Clean up press at cycle 10, held → btn_level[3]=1 at cycle 16; evt_valid=1 with evt_dir=3 at 17, held until ack; ack at 25 → evt_valid=0 at 26.
- Up bounces 1/0/1 with 2-cycle gaps, then steady from cycle 20 → exactly one event, evt_valid at 27, no multi_err.
- Up held, then left pressed → no second event; release both, then press left → event with evt_dir=1.
- Up and down rise in the same raw cycle → multi_err one-cycle pulse, evt_valid stays 0; after all released, a right press → event with evt_dir=0.
- Event dir=3 pending and unacked, release up and press right → evt_ovf one-cycle pulse, evt_dir stays 3. Repeat with evt_ack asserted in the new event's cycle → evt_valid stays 1, evt_dir=0, no evt_ovf.
- Center press → center_pulse high exactly one cycle, evt_valid stays 0. Then assert w_rst_n=0 mid-debounce of up → all outputs 0 within the same cycle; after release with up still held → event at DEBOUNCE_CYCLES+3 cycles after the first clock edge.
